// File: rtl/priority_scanner_pkg.sv
// rtl/priority_scanner_pkg.sv - shared types for the priority scanner
`timescale 1ns/1ps
package priority_scanner_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_t;

  typedef enum logic {
    LSB_FIRST = 1'b0,
    MSB_FIRST = 1'b1
  } scan_order_t;

  // A beat closes its word when nothing else remains behind it (empty word included).
  function automatic logic beat_is_last(input logic single_bit, input logic empty);
    return single_bit | empty;
  endfunction

endpackage

// File: rtl/priority_pick.sv
// rtl/priority_pick.sv - combinational lowest/highest set-bit picker
`timescale 1ns/1ps
module priority_pick #(
  parameter int WIDTH = 16,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] mask,
  input  logic             msb_first,
  output logic [WIDTH-1:0] onehot,
  output logic [IDX_W-1:0] index,
  output logic             single_bit
);

  always_comb begin
    int  pos;
    logic found;
    onehot = '0;
    index  = '0;
    found  = 1'b0;
    pos    = 0;
    // Walk the mask in scan order; the first hit wins.
    for (int i = 0; i < WIDTH; i++) begin
      pos = msb_first ? (WIDTH - 1 - i) : i;
      if (mask[pos] && !found) begin
        onehot[pos] = 1'b1;
        index       = IDX_W'(pos);
        found       = 1'b1;
      end
    end
  end

  assign single_bit = (mask != '0) && ((mask & (mask - WIDTH'(1))) == '0);

endmodule

// File: rtl/priority_scanner.sv
// rtl/priority_scanner.sv - emits set bits of a word one beat at a time
`timescale 1ns/1ps
module priority_scanner
  import priority_scanner_pkg::*;
#(
  parameter int WIDTH = 16,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             msb_first_i,
  input  logic             data_val_i,
  output logic             data_ready_o,
  output logic [WIDTH-1:0] onehot_o,
  output logic [IDX_W-1:0] index_o,
  output logic             last_o,
  output logic             data_val_o,
  input  logic             ready_i
);

  scan_state_t state, state_n;
  scan_order_t order_q, order_n;
  // rem_q holds the bits still to be emitted after the beat currently on the outputs.
  logic [WIDTH-1:0] rem_q, rem_n;
  logic [WIDTH-1:0] onehot_n;
  logic [IDX_W-1:0] index_n;
  logic             last_n, val_n;

  logic [WIDTH-1:0] pick_mask;
  logic             pick_msb;
  logic [WIDTH-1:0] pick_onehot;
  logic [IDX_W-1:0] pick_index;
  logic             pick_single;

  assign pick_mask = (state == ST_IDLE) ? data_i : rem_q;
  assign pick_msb  = (state == ST_IDLE) ? msb_first_i : (order_q == MSB_FIRST);

  priority_pick #(.WIDTH(WIDTH)) u_pick (
    .mask       (pick_mask),
    .msb_first  (pick_msb),
    .onehot     (pick_onehot),
    .index      (pick_index),
    .single_bit (pick_single)
  );

  assign data_ready_o = (state == ST_IDLE);

  always_comb begin
    state_n  = state;
    order_n  = order_q;
    rem_n    = rem_q;
    onehot_n = onehot_o;
    index_n  = index_o;
    last_n   = last_o;
    val_n    = data_val_o;
    case (state)
      ST_IDLE: begin
        if (data_val_i) begin
          state_n  = ST_SCAN;
          order_n  = scan_order_t'(msb_first_i);
          onehot_n = pick_onehot;
          index_n  = pick_index;
          last_n   = beat_is_last(pick_single, pick_mask == '0);
          rem_n    = data_i & ~pick_onehot;
          val_n    = 1'b1;
        end
      end
      ST_SCAN: begin
        if (data_val_o && ready_i) begin
          if (last_o) begin
            state_n  = ST_IDLE;
            rem_n    = '0;
            onehot_n = '0;
            index_n  = '0;
            last_n   = 1'b0;
            val_n    = 1'b0;
          end else begin
            onehot_n = pick_onehot;
            index_n  = pick_index;
            last_n   = beat_is_last(pick_single, pick_mask == '0);
            rem_n    = rem_q & ~pick_onehot;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state      <= ST_IDLE;
      order_q    <= LSB_FIRST;
      rem_q      <= '0;
      onehot_o   <= '0;
      index_o    <= '0;
      last_o     <= 1'b0;
      data_val_o <= 1'b0;
    end else begin
      state      <= state_n;
      order_q    <= order_n;
      rem_q      <= rem_n;
      onehot_o   <= onehot_n;
      index_o    <= index_n;
      last_o     <= last_n;
      data_val_o <= val_n;
    end
  end

endmodule
